alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control FSM that sequences one decoded instruction at a time through the ALU datapath: operand fetch, memory access, execute, writeback, PC update.
- Sits between the instruction decoder and the ALU / general register file / memory controller.
- Drives ALU_Sel, MemIO, MenagePC and register read/write strobes, and waits on the RegRdy / ValidMemData handshakes.

Parameters:
- TIMEOUT_CYCLES, 16: maximum MEMWAIT cycles before fault; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- InstrValid  in  1  decoder offers an instruction
- InstrReady  out  1  sequencer accepts; transfer when both high
- InstrOpcode  in  8  opcode; [7:6] class: 00 reg-op, 01 load, 10 store, 11 PC-op; 8'h00 = NOP
- InstrData  in  24  decoder immediate, latched on accept
- LatchedData  out  24  held copy of InstrData for the datapath
- RegRdy  in  1  general register ready
- ValidMemData  in  1  memory transaction complete
- RegRead  out  1  request operand read
- RegWrite  out  1  request result writeback
- ALU_Sel  out  8  ALU operation select
- MemIO  out  2  00 NOP, 01 read, 10 write
- MenagePC  out  3  000 NOP, 001 inc, 011 set, 100 add
- Busy  out  1  high in any state except IDLE
- Done  out  1  one-cycle pulse on instruction retire
- Fault  out  1  memory timeout flag

Behaviour:
- Moore FSM; all outputs are registered or decoded from registered state only.
- Reset: state IDLE; InstrReady=1; all other outputs 0; latched opcode and data 0; timeout counter 0.
- rst mid-operation: IDLE on the next edge. Any in-flight MemIO or RegWrite drops that cycle. No Done is pulsed.
- IDLE:
  - InstrReady=1.
  - On InstrValid, latch opcode and data.
  - Opcode 8'h00 -> PCUPD; otherwise -> OPFETCH.
  - Fault clears on accept.
- OPFETCH:
  - RegRead=1; hold until RegRdy sampled high.
  - Then: class 01 -> MEMWAIT (read); class 10 -> MEMWAIT (write); classes 00/11 -> EXEC.
- MEMWAIT:
  - MemIO=01 (load) or 10 (store), held constant.
  - Counter clears on entry and increments each cycle.
  - ValidMemData high: load -> EXEC, store -> PCUPD.
  - Counter reaches TIMEOUT_CYCLES with ValidMemData low -> FAULT. If ValidMemData arrives on the final cycle, it wins.
- EXEC:
  - Exactly one cycle; ALU_Sel = latched opcode (0 in all other states).
  - Next state: classes 00/01 -> WRBACK; class 11 -> PCUPD.
- WRBACK: RegWrite=1 until RegRdy sampled high, then -> PCUPD.
- PCUPD:
  - One cycle; Done=1.
  - MenagePC: class 11 with opcode[1:0]=01 -> 011; class 11 with 10 -> 100; all other cases -> 001.
  - Next state: IDLE.
- FAULT:
  - One cycle; MemIO=00; Fault set (sticky until next accept); no Done; no PC change.
  - Next state: IDLE.
- Handshake rules:
  - InstrValid is ignored while not in IDLE.
  - ValidMemData is ignored outside MEMWAIT.
  - RegRdy is ignored outside OPFETCH and WRBACK.
- Latency with ready inputs already high (accept edge = T):
  - NOP: Done at T+1, InstrReady at T+2.
  - Reg-op: OPFETCH T+1, EXEC T+2, WRBACK T+3, Done T+4, IDLE T+5.

Optional Feature:
- Macro: ALU_SEQ_PERF_CNT_EN.
- Defined: adds outputs InstrCount[31:0] and StallCount[31:0].
  - InstrCount increments on each Done.
  - StallCount increments on each cycle spent in OPFETCH/WRBACK with RegRdy low, or in MEMWAIT with ValidMemData low.
  - Both clear on rst and wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. Reset, then InstrValid with opcode 8'h00 -> Done at T+1 with MenagePC=001, InstrReady=0 at T+1, InstrReady=1 at T+2.
2. Opcode 8'h05, RegRdy tied 1 -> ALU_Sel=8'h05 only at T+2, RegWrite at T+3, Done and MenagePC=001 at T+4.
3. Load opcode 8'h41, ValidMemData after 3 cycles -> MemIO=01 for exactly 3 cycles, then EXEC (ALU_Sel=8'h41), WRBACK, Done; Fault=0.
4. Store opcode 8'h80, ValidMemData never asserted, TIMEOUT_CYCLES=16 -> MemIO=10 for 16 cycles, FAULT with Fault=1, no Done, IDLE; next accept clears Fault.
5. PC-op opcodes 8'hC1 and 8'hC2 -> MenagePC=011 and 100 respectively in PCUPD; InstrValid held high during Busy is not accepted twice.
6. rst asserted mid-WRBACK with RegRdy=0 -> next cycle IDLE, RegWrite=0, Done never pulses; with ALU_SEQ_PERF_CNT_EN, InstrCount=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM sequencing one decoded instruction through fetch, memory, execute,
// writeback and PC update. Optional perf counters enabled by ALU_SEQ_PERF_CNT_EN.
module alu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        InstrValid,
    output logic        InstrReady,
    input  logic [7:0]  InstrOpcode,
    input  logic [23:0] InstrData,
    output logic [23:0] LatchedData,
    input  logic        RegRdy,
    input  logic        ValidMemData,
    output logic        RegRead,
    output logic        RegWrite,
    output logic [7:0]  ALU_Sel,
    output logic [1:0]  MemIO,
    output logic [2:0]  MenagePC,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] InstrCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [2:0] {
        StIdle, StOpFetch, StMemWait, StExec, StWrBack, StPcUpd, StFault
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt =
        CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

    state_e           r_state;
    logic [7:0]       r_opcode;
    logic [23:0]      r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_instr_ready;
    logic             r_reg_read;
    logic             r_reg_write;
    logic [7:0]       r_alu_sel;
    logic [1:0]       r_mem_io;
    logic [2:0]       r_menage_pc;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;

    state_e           w_state_d;
    logic [7:0]       w_opcode_d;
    logic [23:0]      w_data_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_accept;
    logic [2:0]       w_menage_pc;

    always_comb begin
        w_state_d  = r_state;
        w_opcode_d = r_opcode;
        w_data_d   = r_data;
        w_cnt_d    = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            StIdle: begin
                if (InstrValid) begin
                    w_accept   = 1'b1;
                    w_opcode_d = InstrOpcode;
                    w_data_d   = InstrData;
                    w_state_d  = (InstrOpcode == 8'h00) ? StPcUpd : StOpFetch;
                end
            end
            StOpFetch: begin
                if (RegRdy) begin
                    w_cnt_d = '0;
                    if (r_opcode[7:6] == 2'b01 || r_opcode[7:6] == 2'b10) begin
                        w_state_d = StMemWait;
                    end else begin
                        w_state_d = StExec;
                    end
                end
            end
            StMemWait: begin
                // A completion on the last allowed cycle beats the timeout.
                if (ValidMemData) begin
                    w_state_d = (r_opcode[7:6] == 2'b01) ? StExec : StPcUpd;
                end else if (TIMEOUT_CYCLES != 32'd0 && r_cnt == LastCnt) begin
                    w_state_d = StFault;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StExec:   w_state_d = (r_opcode[7:6] == 2'b11) ? StPcUpd : StWrBack;
            StWrBack: if (RegRdy) w_state_d = StPcUpd;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_menage_pc = 3'b001;
        if (w_opcode_d[7:6] == 2'b11) begin
            if (w_opcode_d[1:0] == 2'b01) begin
                w_menage_pc = 3'b011;
            end else if (w_opcode_d[1:0] == 2'b10) begin
                w_menage_pc = 3'b100;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_opcode      <= 8'h00;
            r_data        <= 24'h000000;
            r_cnt         <= '0;
            r_instr_ready <= 1'b1;
            r_reg_read    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_alu_sel     <= 8'h00;
            r_mem_io      <= 2'b00;
            r_menage_pc   <= 3'b000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
            InstrCount    <= 32'd0;
            StallCount    <= 32'd0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_opcode      <= w_opcode_d;
            r_data        <= w_data_d;
            r_cnt         <= w_cnt_d;
            r_instr_ready <= (w_state_d == StIdle);
            r_reg_read    <= (w_state_d == StOpFetch);
            r_reg_write   <= (w_state_d == StWrBack);
            r_alu_sel     <= (w_state_d == StExec) ? w_opcode_d : 8'h00;
            r_mem_io      <= (w_state_d != StMemWait) ? 2'b00 :
                             (w_opcode_d[7:6] == 2'b01) ? 2'b01 : 2'b10;
            r_menage_pc   <= (w_state_d == StPcUpd) ? w_menage_pc : 3'b000;
            r_busy        <= (w_state_d != StIdle);
            r_done        <= (w_state_d == StPcUpd);
            if (w_accept) begin
                r_fault <= 1'b0;
            end else if (w_state_d == StFault) begin
                r_fault <= 1'b1;
            end
`ifdef ALU_SEQ_PERF_CNT_EN
            if (r_done) begin
                InstrCount <= InstrCount + 32'd1;
            end
            if (((r_state == StOpFetch || r_state == StWrBack) && !RegRdy) ||
                (r_state == StMemWait && !ValidMemData)) begin
                StallCount <= StallCount + 32'd1;
            end
`endif
        end
    end

    assign InstrReady  = r_instr_ready;
    assign LatchedData = r_data;
    assign RegRead     = r_reg_read;
    assign RegWrite    = r_reg_write;
    assign ALU_Sel     = r_alu_sel;
    assign MemIO       = r_mem_io;
    assign MenagePC    = r_menage_pc;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Fault       = r_fault;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Table-driven bench for alu_op_sequencer: per-instruction cycle traces against hand-computed
// expectations, plus reset and mid-writeback reset sequences.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        InstrValid;
    logic        InstrReady;
    logic [7:0]  InstrOpcode;
    logic [23:0] InstrData;
    logic [23:0] LatchedData;
    logic        RegRdy;
    logic        ValidMemData;
    logic        RegRead;
    logic        RegWrite;
    logic [7:0]  ALU_Sel;
    logic [1:0]  MemIO;
    logic [2:0]  MenagePC;
    logic        Busy;
    logic        Done;
    logic        Fault;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [31:0] InstrCount;
    logic [31:0] StallCount;
`endif

    int n_pass  = 0;
    int n_total = 0;

    alu_op_sequencer #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .InstrOpcode (InstrOpcode),
        .InstrData   (InstrData),
        .LatchedData (LatchedData),
        .RegRdy      (RegRdy),
        .ValidMemData(ValidMemData),
        .RegRead     (RegRead),
        .RegWrite    (RegWrite),
        .ALU_Sel     (ALU_Sel),
        .MemIO       (MemIO),
        .MenagePC    (MenagePC),
        .Busy        (Busy),
        .Done        (Done),
        .Fault       (Fault)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .InstrCount  (InstrCount),
        .StallCount  (StallCount)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // mem_delay: ValidMemData asserted on that MEMWAIT cycle (0 = never).
    // exp_*_cyc: cycle index after the accept edge (1 = first cycle), 0 = never happens.
    typedef struct {
        logic [7:0]  opcode;
        logic [23:0] data;
        int          mem_delay;
        bit          hold_valid;
        int          exp_done_cyc;
        int          exp_alu_cyc;
        int          exp_wr_cyc;
        int          exp_mem_cycles;
        logic [1:0]  exp_memio;
        logic [2:0]  exp_menage;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         done_cyc = 0;
        int         alu_cyc  = 0;
        int         alu_cnt  = 0;
        int         wr_cyc   = 0;
        int         wr_cnt   = 0;
        int         rd_cnt   = 0;
        int         mem_cnt  = 0;
        int         done_cnt = 0;
        logic [7:0] alu_val  = 8'h00;
        logic [1:0] mem_val  = 2'b00;
        logic [2:0] pc_val   = 3'b000;
        int         stray_pc = 0;
        bit         fin      = 1'b0;
        string      p;
        p = $sformatf("v%0d_op%02h", idx, v.opcode);
        check({p, "_ready_idle"}, {31'd0, InstrReady}, 32'd1);
        InstrValid   = 1'b1;
        InstrOpcode  = v.opcode;
        InstrData    = v.data;
        RegRdy       = 1'b1;
        ValidMemData = 1'b1;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check({p, "_ready_busy"}, {31'd0, InstrReady}, 32'd0);
                check({p, "_busy"}, {31'd0, Busy}, 32'd1);
                check({p, "_latched"}, {8'd0, LatchedData}, {8'd0, v.data});
                check({p, "_fault_clr"}, {31'd0, Fault}, 32'd0);
                if (v.hold_valid) begin
                    // Changed payload must not be picked up while busy.
                    InstrOpcode = 8'h05;
                    InstrData   = 24'hFFFFFF;
                end else begin
                    InstrValid = 1'b0;
                end
            end
            if (RegRead) rd_cnt++;
            if (ALU_Sel != 8'h00) begin
                alu_cnt++;
                alu_cyc = cyc;
                alu_val = ALU_Sel;
            end
            if (RegWrite) begin
                wr_cnt++;
                wr_cyc = cyc;
            end
            if (MemIO != 2'b00) begin
                mem_cnt++;
                mem_val      = MemIO;
                ValidMemData = (v.mem_delay != 0 && mem_cnt == v.mem_delay);
            end else begin
                ValidMemData = 1'b1;
            end
            if (MenagePC != 3'b000 && !Done) stray_pc++;
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
                pc_val   = MenagePC;
                fin      = 1'b1;
            end
            if (Fault) fin = 1'b1;
            if (fin) begin
                check({p, "_latched_end"}, {8'd0, LatchedData}, {8'd0, v.data});
                InstrValid = 1'b0;
            end
        end
        InstrValid   = 1'b0;
        ValidMemData = 1'b0;
        check({p, "_finished"}, {31'd0, fin}, 32'd1);
        check({p, "_done_cyc"}, done_cyc, v.exp_done_cyc);
        check({p, "_done_cnt"}, done_cnt, (v.exp_done_cyc != 0) ? 1 : 0);
        check({p, "_menage"}, {29'd0, pc_val}, {29'd0, v.exp_menage});
        check({p, "_stray_pc"}, stray_pc, 0);
        check({p, "_alu_cyc"}, alu_cyc, v.exp_alu_cyc);
        check({p, "_alu_cnt"}, alu_cnt, (v.exp_alu_cyc != 0) ? 1 : 0);
        check({p, "_alu_val"}, {24'd0, alu_val}, (v.exp_alu_cyc != 0) ? {24'd0, v.opcode} : 32'd0);
        check({p, "_wr_cyc"}, wr_cyc, v.exp_wr_cyc);
        check({p, "_wr_cnt"}, wr_cnt, (v.exp_wr_cyc != 0) ? 1 : 0);
        check({p, "_rd_cnt"}, rd_cnt, (v.opcode != 8'h00) ? 1 : 0);
        check({p, "_mem_cycles"}, mem_cnt, v.exp_mem_cycles);
        check({p, "_memio"}, {30'd0, mem_val}, {30'd0, v.exp_memio});
        @(negedge clk);
        check({p, "_ready_after"}, {31'd0, InstrReady}, 32'd1);
        check({p, "_busy_after"}, {31'd0, Busy}, 32'd0);
        check({p, "_done_after"}, {31'd0, Done}, 32'd0);
        check({p, "_fault_after"}, {31'd0, Fault}, {31'd0, v.exp_fault});
        @(negedge clk);
        check({p, "_idle_stays"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 24'h123456, 0,  1'b0, 1,  0, 0, 0,  2'b00, 3'b001, 1'b0};
        vecs[1]  = '{8'h05, 24'hABCDEF, 0,  1'b0, 4,  2, 3, 0,  2'b00, 3'b001, 1'b0};
        vecs[2]  = '{8'h41, 24'h000001, 3,  1'b0, 7,  5, 6, 3,  2'b01, 3'b001, 1'b0};
        vecs[3]  = '{8'h80, 24'h0000AA, 0,  1'b0, 0,  0, 0, 16, 2'b10, 3'b000, 1'b1};
        vecs[4]  = '{8'hC1, 24'h111111, 0,  1'b0, 3,  2, 0, 0,  2'b00, 3'b011, 1'b0};
        vecs[5]  = '{8'hC2, 24'h222222, 0,  1'b1, 3,  2, 0, 0,  2'b00, 3'b100, 1'b0};
        vecs[6]  = '{8'h82, 24'h333333, 1,  1'b0, 3,  0, 0, 1,  2'b10, 3'b001, 1'b0};
        vecs[7]  = '{8'h90, 24'h444444, 16, 1'b0, 18, 0, 0, 16, 2'b10, 3'b001, 1'b0};
        vecs[8]  = '{8'h7F, 24'h555555, 1,  1'b0, 5,  3, 4, 1,  2'b01, 3'b001, 1'b0};
        vecs[9]  = '{8'hC3, 24'h666666, 0,  1'b0, 3,  2, 0, 0,  2'b00, 3'b001, 1'b0};
        vecs[10] = '{8'h3F, 24'h777777, 0,  1'b0, 4,  2, 3, 0,  2'b00, 3'b001, 1'b0};

        rst          = 1'b1;
        InstrValid   = 1'b0;
        InstrOpcode  = 8'h00;
        InstrData    = 24'h000000;
        RegRdy       = 1'b0;
        ValidMemData = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, InstrReady}, 32'd1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_fault", {31'd0, Fault}, 32'd0);
        check("rst_memio", {30'd0, MemIO}, 32'd0);
        check("rst_menage", {29'd0, MenagePC}, 32'd0);
        check("rst_rdwr", {30'd0, RegRead, RegWrite}, 32'd0);
        check("rst_alu", {24'd0, ALU_Sel}, 32'd0);
        check("rst_latched", {8'd0, LatchedData}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Operand stall, then reset while writeback is stalled.
        InstrValid  = 1'b1;
        InstrOpcode = 8'h05;
        InstrData   = 24'h0A0B0C;
        RegRdy      = 1'b0;
        @(negedge clk);
        InstrValid = 1'b0;
        check("stall_rd1", {31'd0, RegRead}, 32'd1);
        @(negedge clk);
        check("stall_rd2", {31'd0, RegRead}, 32'd1);
        check("stall_alu", {24'd0, ALU_Sel}, 32'd0);
        RegRdy = 1'b1;
        @(negedge clk);
        check("stall_exec", {24'd0, ALU_Sel}, 32'h05);
        RegRdy = 1'b0;
        @(negedge clk);
        check("stall_wr1", {31'd0, RegWrite}, 32'd1);
        @(negedge clk);
        check("stall_wr2", {31'd0, RegWrite}, 32'd1);
        check("stall_nodone", {31'd0, Done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_wr", {31'd0, RegWrite}, 32'd0);
        check("midrst_ready", {31'd0, InstrReady}, 32'd1);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_latched", {8'd0, LatchedData}, 32'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
        check("midrst_icount", InstrCount, 32'd0);
        check("midrst_scount", StallCount, 32'd0);
`endif
        RegRdy = 1'b1;
        @(negedge clk);
        check("postrst_done", {31'd0, Done}, 32'd0);
        check("postrst_busy", {31'd0, Busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
